// File: rtl/led_port_driver.sv
// LED output stage: per-channel direct, blink, PWM or forced-on modes
// driven from SoC port bits, with selectable pin polarity.
module led_port_driver #(
  parameter int CHANNELS   = 6,
  parameter int PWM_BITS   = 4,
  parameter int PRESCALE   = 16,
  parameter int BLINK_BITS = 5,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] portIn,
  input  logic                cfgWe,
  input  logic [7:0]          cfgAddr,
  input  logic [7:0]          cfgData,
  output logic [CHANNELS-1:0] leds,
  output logic                periodStart
);

  localparam int PS_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST =
    PS_W'(PRESCALE - 1);
  localparam logic [CHANNELS-1:0] OFF =
    {CHANNELS{ACTIVE_LOW}};

  logic [PS_W-1:0]       presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [1:0]            mode [CHANNELS];
  logic [PWM_BITS-1:0]   duty [CHANNELS];
  logic [CHANNELS-1:0]   lit;
  logic                  tick;
  logic                  wrap;
  logic                  phase;
  logic                  unused_cfg;

  assign tick  = (presc == PS_LAST);
  assign wrap  = tick & (&pwm_cnt);
  assign phase = blink_cnt[BLINK_BITS-1];
  assign unused_cfg = ^cfgData;

  // Counters run freely, independent of channel modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      periodStart <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      periodStart <= wrap;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap)
        blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Out-of-range addresses match no channel and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i] <= 2'b00;
        duty[i] <= '0;
      end
    end else if (cfgWe) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfgAddr == 8'(i)) begin
          mode[i] <= cfgData[7:6];
          duty[i] <= cfgData[PWM_BITS-1:0];
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode[i])
        2'b00: lit[i] = portIn[i];
        2'b01: lit[i] = portIn[i] & phase;
        2'b10: lit[i] = portIn[i] &
                 ((&duty[i]) | (pwm_cnt < duty[i]));
        2'b11: lit[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      leds <= OFF;
    else
      leds <= lit ^ OFF;
  end

endmodule

// File: tb/tb_led_port_driver.sv
// Directed bench for led_port_driver: PRESCALE=4, PWM_BITS=4,
// BLINK_BITS=2, active-low pins, 64-cycle PWM period.
module tb_led_port_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] portIn;
  logic       cfgWe;
  logic [7:0] cfgAddr;
  logic [7:0] cfgData;
  logic [5:0] leds;
  logic       periodStart;

  int n_cmp = 0;
  int n_err = 0;

  led_port_driver #(
    .CHANNELS(6), .PWM_BITS(4), .PRESCALE(4),
    .BLINK_BITS(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .portIn(portIn),
    .cfgWe(cfgWe), .cfgAddr(cfgAddr),
    .cfgData(cfgData), .leds(leds),
    .periodStart(periodStart)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this, the last reset edge is edge 0.
  task automatic do_reset();
    reset = 1'b1;
    cfgWe = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] d);
    cfgWe = 1'b1;
    cfgAddr = a;
    cfgData = d;
    step();
    cfgWe = 1'b0;
  endtask

  task automatic test_reset();
    portIn = 6'b000000;
    do_reset();
    n_cmp++;
    if (leds !== 6'b111111) begin
      n_err++;
      $display("FAIL reset_leds got %b want %b",
               leds, 6'b111111);
    end
    n_cmp++;
    if (periodStart !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ps got %b want 0",
               periodStart);
    end
  endtask

  task automatic test_direct();
    portIn = 6'b000101;
    step();
    n_cmp++;
    if (leds !== 6'b111010) begin
      n_err++;
      $display("FAIL direct_a got %b want %b",
               leds, 6'b111010);
    end
    portIn = 6'b000000;
    step();
    n_cmp++;
    if (leds !== 6'b111111) begin
      n_err++;
      $display("FAIL direct_b got %b want %b",
               leds, 6'b111111);
    end
    portIn = 6'b101010;
    step();
    n_cmp++;
    if (leds !== 6'b010101) begin
      n_err++;
      $display("FAIL direct_c got %b want %b",
               leds, 6'b010101);
    end
  endtask

  task automatic test_pwm();
    int on_cnt;
    do_reset();
    portIn = 6'b000001;
    wr(8'd0, 8'h84);
    on_cnt = 0;
    for (int e = 2; e <= 128; e++) begin
      step();
      if (e == 64) begin
        n_cmp++;
        if (periodStart !== 1'b1) begin
          n_err++;
          $display("FAIL pwm_ps64 got %b want 1",
                   periodStart);
        end
        n_cmp++;
        if (leds[0] !== 1'b1) begin
          n_err++;
          $display("FAIL pwm_e64 got %b want 1",
                   leds[0]);
        end
      end
      if (e == 65) begin
        n_cmp++;
        if (periodStart !== 1'b0) begin
          n_err++;
          $display("FAIL pwm_ps65 got %b want 0",
                   periodStart);
        end
        n_cmp++;
        if (leds[0] !== 1'b0) begin
          n_err++;
          $display("FAIL pwm_e65 got %b want 0",
                   leds[0]);
        end
      end
      if (e == 81) begin
        n_cmp++;
        if (leds[0] !== 1'b1) begin
          n_err++;
          $display("FAIL pwm_e81 got %b want 1",
                   leds[0]);
        end
      end
      if (e >= 65 && leds[0] == 1'b0)
        on_cnt++;
    end
    n_cmp++;
    if (on_cnt != 16) begin
      n_err++;
      $display("FAIL pwm_on_count got %0d want 16",
               on_cnt);
    end
    n_cmp++;
    if (periodStart !== 1'b1) begin
      n_err++;
      $display("FAIL pwm_ps128 got %b want 1",
               periodStart);
    end
    n_cmp++;
    if (leds[5:1] !== 5'b11111) begin
      n_err++;
      $display("FAIL pwm_others got %b want 11111",
               leds[5:1]);
    end
    // Full duty: continuously lit.
    wr(8'd0, 8'h8F);
    on_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (leds[0] == 1'b0)
        on_cnt++;
    end
    n_cmp++;
    if (on_cnt != 64) begin
      n_err++;
      $display("FAIL pwm_full got %0d want 64",
               on_cnt);
    end
    // Zero duty: never lit.
    wr(8'd0, 8'h80);
    on_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (leds[0] == 1'b0)
        on_cnt++;
    end
    n_cmp++;
    if (on_cnt != 0) begin
      n_err++;
      $display("FAIL pwm_zero got %0d want 0",
               on_cnt);
    end
  endtask

  task automatic test_blink();
    int on_a;
    int on_b;
    do_reset();
    portIn = 6'b000010;
    wr(8'd1, 8'h40);
    on_a = 0;
    on_b = 0;
    for (int e = 2; e <= 400; e++) begin
      step();
      if (e <= 128 && leds[1] == 1'b0)
        on_a++;
      if (e >= 129 && e <= 384 && leds[1] == 1'b0)
        on_b++;
      if (e == 129 || e == 256 || e == 385) begin
        n_cmp++;
        if (leds[1] !== 1'b0) begin
          n_err++;
          $display("FAIL blink_on e%0d got %b want 0",
                   e, leds[1]);
        end
      end
      if (e == 128 || e == 257 || e == 384) begin
        n_cmp++;
        if (leds[1] !== 1'b1) begin
          n_err++;
          $display("FAIL blink_off e%0d got %b want 1",
                   e, leds[1]);
        end
      end
    end
    n_cmp++;
    if (on_a != 0) begin
      n_err++;
      $display("FAIL blink_first got %0d want 0", on_a);
    end
    n_cmp++;
    if (on_b != 128) begin
      n_err++;
      $display("FAIL blink_win got %0d want 128", on_b);
    end
  endtask

  task automatic test_forced();
    do_reset();
    portIn = 6'b000000;
    wr(8'd2, 8'hC0);
    n_cmp++;
    if (leds !== 6'b111111) begin
      n_err++;
      $display("FAIL forced_lat got %b want %b",
               leds, 6'b111111);
    end
    step();
    n_cmp++;
    if (leds !== 6'b111011) begin
      n_err++;
      $display("FAIL forced_on got %b want %b",
               leds, 6'b111011);
    end
    wr(8'd6, 8'hC0);
    step();
    n_cmp++;
    if (leds !== 6'b111011) begin
      n_err++;
      $display("FAIL ign_c0 got %b want %b",
               leds, 6'b111011);
    end
    // Duty-0 PWM writes would darken any channel they hit.
    portIn = 6'b111111;
    wr(8'd6, 8'h80);
    wr(8'h82, 8'h80);
    wr(8'hFF, 8'h80);
    step();
    n_cmp++;
    if (leds !== 6'b000000) begin
      n_err++;
      $display("FAIL ign_80 got %b want %b",
               leds, 6'b000000);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    portIn = 6'b000000;
    wr(8'd3, 8'hC0);
    repeat (20) step();
    n_cmp++;
    if (leds !== 6'b110111) begin
      n_err++;
      $display("FAIL prio_pre got %b want %b",
               leds, 6'b110111);
    end
    reset = 1'b1;
    cfgWe = 1'b1;
    cfgAddr = 8'd3;
    cfgData = 8'hC0;
    step();
    reset = 1'b0;
    cfgWe = 1'b0;
    n_cmp++;
    if (leds !== 6'b111111) begin
      n_err++;
      $display("FAIL prio_rst got %b want %b",
               leds, 6'b111111);
    end
    for (int e = 1; e <= 65; e++) begin
      step();
      if (e == 2) begin
        n_cmp++;
        if (leds !== 6'b111111) begin
          n_err++;
          $display("FAIL prio_mode got %b want %b",
                   leds, 6'b111111);
        end
      end
      if (e == 63 || e == 65) begin
        n_cmp++;
        if (periodStart !== 1'b0) begin
          n_err++;
          $display("FAIL prio_ps e%0d got %b want 0",
                   e, periodStart);
        end
      end
      if (e == 64) begin
        n_cmp++;
        if (periodStart !== 1'b1) begin
          n_err++;
          $display("FAIL prio_ps64 got %b want 1",
                   periodStart);
        end
      end
    end
    portIn = 6'b001000;
    step();
    n_cmp++;
    if (leds !== 6'b110111) begin
      n_err++;
      $display("FAIL prio_direct got %b want %b",
               leds, 6'b110111);
    end
  endtask

  task automatic test_live_duty();
    do_reset();
    portIn = 6'b000001;
    wr(8'd0, 8'h84);
    repeat (23) step();
    wr(8'd0, 8'h8A);
    n_cmp++;
    if (leds[0] !== 1'b1) begin
      n_err++;
      $display("FAIL live_e25 got %b want 1", leds[0]);
    end
    step();
    n_cmp++;
    if (leds[0] !== 1'b0) begin
      n_err++;
      $display("FAIL live_e26 got %b want 0", leds[0]);
    end
    repeat (14) step();
    n_cmp++;
    if (leds[0] !== 1'b0) begin
      n_err++;
      $display("FAIL live_e40 got %b want 0", leds[0]);
    end
    step();
    n_cmp++;
    if (leds[0] !== 1'b1) begin
      n_err++;
      $display("FAIL live_e41 got %b want 1", leds[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    portIn = '0;
    cfgWe = 1'b0;
    cfgAddr = '0;
    cfgData = '0;
    test_reset();
    test_direct();
    test_pwm();
    test_blink();
    test_forced();
    test_reset_priority();
    test_live_duty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
